// File: rtl/frog_pkg.sv
// Shared encodings and default geometry for the frog hop controller.
package frog_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOP  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    localparam int DEF_D_WIDTH  = 640;
    localparam int DEF_D_HEIGHT = 480;
    localparam int DEF_HOP_DIS  = 48;
    localparam int DEF_STEP     = 4;

    // press = {up, down, left, right}, active-high; up wins, right is the fallback
    function automatic logic [1:0] prio_dir(input logic [3:0] press);
        if (press[3])      return DIR_UP;
        else if (press[2]) return DIR_DOWN;
        else if (press[1]) return DIR_LEFT;
        else               return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/frog_hop_ctrl_btn_capture.sv
// Button front end: active-low inversion, falling-edge detect and priority encode.
module btn_capture
    import frog_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_up_btn,
    input  logic       i_down_btn,
    input  logic       i_left_btn,
    input  logic       i_right_btn,
    output logic       o_held_vld,
    output logic [1:0] o_held_dir,
    output logic       o_edge_vld,
    output logic [1:0] o_edge_dir
);

    logic [3:0] press;
    logic [3:0] press_prev_q;
    logic [3:0] fall;

    assign press = ~{i_up_btn, i_down_btn, i_left_btn, i_right_btn};
    assign fall  = press & ~press_prev_q;

    // Previous press levels, sampled every clock so edges are seen between strobes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) press_prev_q <= 4'b0000;
        else          press_prev_q <= press;
    end

    assign o_held_vld = |press;
    assign o_held_dir = prio_dir(press);
    assign o_edge_vld = |fall;
    assign o_edge_dir = prio_dir(fall);

endmodule

// File: rtl/frog_hop_ctrl.sv
// Discrete-hop sprite controller: bounded hops, one buffered next hop,
// timed death/respawn and an up-hop score counter.
//
// state   | meaning
// IDLE    | at rest, a tick with a request may launch a hop
// HOP     | moving STEP px per tick, capturing one pending press
// DEAD    | respawned at spawn point, counting down respawn frames
module frog_hop_ctrl
    import frog_pkg::*;
#(
    parameter int H_WIDTH        = 11,
    parameter int H_HEIGHT       = 11,
    parameter int IX             = 320,
    parameter int IY             = 469,
    parameter int HOP_DIS        = DEF_HOP_DIS,
    parameter int STEP           = DEF_STEP,
    parameter int D_WIDTH        = DEF_D_WIDTH,
    parameter int D_HEIGHT       = DEF_D_HEIGHT,
    parameter int RESPAWN_FRAMES = 30,
    parameter int CW             = 12
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ani_stb,
    input  logic          i_animate,
    input  logic          i_up_btn,
    input  logic          i_down_btn,
    input  logic          i_left_btn,
    input  logic          i_right_btn,
    input  logic          i_dead,
    output logic [CW-1:0] o_x1,
    output logic [CW-1:0] o_x2,
    output logic [CW-1:0] o_y1,
    output logic [CW-1:0] o_y2,
    output logic          o_busy,
    output logic [1:0]    o_dir,
    output logic          o_dead_anim,
    output logic [7:0]    o_hops
);

    localparam int STEPS = HOP_DIS / STEP;
    localparam int SCW   = $clog2(STEPS + 1);
    localparam int FCW   = $clog2(RESPAWN_FRAMES + 1);

    localparam logic [CW-1:0]  IX_C     = CW'(IX);
    localparam logic [CW-1:0]  IY_C     = CW'(IY);
    localparam logic [CW-1:0]  STEP_C   = CW'(STEP);
    localparam logic [CW-1:0]  HW_C     = CW'(H_WIDTH);
    localparam logic [CW-1:0]  HH_C     = CW'(H_HEIGHT);
    localparam logic [SCW-1:0] STEPS_C  = SCW'(STEPS);
    localparam logic [SCW-1:0] SC_ONE   = SCW'(1);
    localparam logic [FCW-1:0] FRAMES_C = FCW'(RESPAWN_FRAMES);
    localparam logic [FCW-1:0] FC_ONE   = FCW'(1);
    // Bounds compared one bit wider so the sums can never wrap
    localparam logic [CW:0]    V_REACH  = (CW+1)'(HOP_DIS + H_HEIGHT);
    localparam logic [CW:0]    H_REACH  = (CW+1)'(HOP_DIS + H_WIDTH);
    localparam logic [CW:0]    Y_LIMIT  = (CW+1)'(D_HEIGHT - 1);
    localparam logic [CW:0]    X_LIMIT  = (CW+1)'(D_WIDTH - 1);

    state_e         state_q;
    logic [CW-1:0]  x_q, y_q;
    logic [1:0]     dir_q;
    logic [7:0]     hops_q;
    logic [SCW-1:0] step_cnt_q;
    logic [FCW-1:0] frame_cnt_q;
    logic           pend_vld_q;
    logic [1:0]     pend_dir_q;

    logic           held_vld, edge_vld;
    logic [1:0]     held_dir, edge_dir;
    logic           tick;
    logic           req_vld;
    logic [1:0]     req_dir;
    logic           legal_d;
    logic [CW-1:0]  x_d, y_d;

    btn_capture u_btn (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_up_btn    (i_up_btn),
        .i_down_btn  (i_down_btn),
        .i_left_btn  (i_left_btn),
        .i_right_btn (i_right_btn),
        .o_held_vld  (held_vld),
        .o_held_dir  (held_dir),
        .o_edge_vld  (edge_vld),
        .o_edge_dir  (edge_dir)
    );

    assign tick    = i_ani_stb & i_animate;
    assign req_vld = pend_vld_q | held_vld;
    assign req_dir = pend_vld_q ? pend_dir_q : held_dir;

    // Legality of the requested hop and the one-step-advanced position
    always_comb begin
        legal_d = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        case (req_dir)
            DIR_UP:   legal_d = {1'b0, y_q} >= V_REACH;
            DIR_DOWN: legal_d = ({1'b0, y_q} + V_REACH) <= Y_LIMIT;
            DIR_LEFT: legal_d = {1'b0, x_q} >= H_REACH;
            default:  legal_d = ({1'b0, x_q} + H_REACH) <= X_LIMIT;
        endcase
        case (dir_q)
            DIR_UP:   y_d = y_q - STEP_C;
            DIR_DOWN: y_d = y_q + STEP_C;
            DIR_LEFT: x_d = x_q - STEP_C;
            default:  x_d = x_q + STEP_C;
        endcase
    end

    // Hop/death state machine with position, counters and pending buffer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= IX_C;
            y_q         <= IY_C;
            dir_q       <= DIR_UP;
            hops_q      <= 8'd0;
            step_cnt_q  <= '0;
            frame_cnt_q <= '0;
            pend_vld_q  <= 1'b0;
            pend_dir_q  <= DIR_UP;
        end else if (tick && i_dead) begin
            state_q     <= ST_DEAD;
            x_q         <= IX_C;
            y_q         <= IY_C;
            hops_q      <= 8'd0;
            pend_vld_q  <= 1'b0;
            frame_cnt_q <= FRAMES_C;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick && req_vld) begin
                        pend_vld_q <= 1'b0;
                        if (legal_d) begin
                            dir_q      <= req_dir;
                            step_cnt_q <= STEPS_C;
                            state_q    <= ST_HOP;
                        end
                    end
                end
                ST_HOP: begin
                    if (!pend_vld_q && edge_vld) begin
                        pend_vld_q <= 1'b1;
                        pend_dir_q <= edge_dir;
                    end
                    if (tick) begin
                        x_q        <= x_d;
                        y_q        <= y_d;
                        step_cnt_q <= step_cnt_q - SC_ONE;
                        if (step_cnt_q == SC_ONE) begin
                            state_q <= ST_IDLE;
                            if (dir_q == DIR_UP && hops_q != 8'hFF)
                                hops_q <= hops_q + 8'd1;
                        end
                    end
                end
                ST_DEAD: begin
                    if (tick) begin
                        frame_cnt_q <= frame_cnt_q - FC_ONE;
                        if (frame_cnt_q == FC_ONE)
                            state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_x1        = x_q - HW_C;
    assign o_x2        = x_q + HW_C;
    assign o_y1        = y_q - HH_C;
    assign o_y2        = y_q + HH_C;
    assign o_busy      = (state_q == ST_HOP);
    assign o_dead_anim = (state_q == ST_DEAD);
    assign o_dir       = dir_q;
    assign o_hops      = hops_q;

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Self-checking bench for frog_hop_ctrl at default parameters.
module tb_frog_hop_ctrl;

    localparam logic [3:0] NONE  = 4'b1111;
    localparam logic [3:0] UP    = 4'b0111;
    localparam logic [3:0] DOWN  = 4'b1011;
    localparam logic [3:0] LEFT  = 4'b1101;
    localparam logic [3:0] RIGHT = 4'b1110;
    localparam logic [59:0] RST_OBS = {12'd309, 12'd331, 12'd458, 12'd480, 1'b0, 2'd0, 1'b0, 8'd0};

    logic clk = 1'b0;
    logic rst_n;
    logic stb, anim, dead;
    logic up_n, down_n, left_n, right_n;
    logic [11:0] o_x1, o_x2, o_y1, o_y2;
    logic        o_busy, o_dead_anim;
    logic [1:0]  o_dir;
    logic [7:0]  o_hops;

    always #5 clk = ~clk;

    frog_hop_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ani_stb   (stb),
        .i_animate   (anim),
        .i_up_btn    (up_n),
        .i_down_btn  (down_n),
        .i_left_btn  (left_n),
        .i_right_btn (right_n),
        .i_dead      (dead),
        .o_x1        (o_x1),
        .o_x2        (o_x2),
        .o_y1        (o_y1),
        .o_y2        (o_y2),
        .o_busy      (o_busy),
        .o_dir       (o_dir),
        .o_dead_anim (o_dead_anim),
        .o_hops      (o_hops)
    );

    typedef struct {
        logic [3:0] btn_n;
        logic       stb;
        logic       anim;
        logic       dead;
        int         ex;
        int         ey;
        logic       busy;
        logic [1:0] dir;
        logic       dan;
        int         hops;
        string      name;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    // expected sprite state while the table is being built
    int ex = 320, ey = 469, ehops = 0, emoves = 0, efr = 0;
    logic [1:0] edir = 2'd0;
    logic ebusy = 1'b0, edan = 1'b0;
    string phase = "reset";

    function automatic void add(input logic [3:0] b, input logic s, input logic a, input logic d);
        vec_t v;
        v.btn_n = b; v.stb = s; v.anim = a; v.dead = d;
        v.ex = ex; v.ey = ey; v.busy = ebusy; v.dir = edir; v.dan = edan; v.hops = ehops;
        v.name = phase;
        tbl.push_back(v);
    endfunction

    function automatic bit legal_hop(input int d);
        case (d)
            0:       return ey >= 48 + 11;
            1:       return ey + 48 + 11 <= 480 - 1;
            2:       return ex >= 48 + 11;
            default: return ex + 48 + 11 <= 640 - 1;
        endcase
    endfunction

    function automatic void hop_start(input int d, input logic [3:0] b);
        edir = 2'(d); ebusy = 1'b1; emoves = 0;
        add(b, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic void hop_move(input bit gap);
        if (gap) add(NONE, 1'b1, 1'b0, 1'b0);
        case (edir)
            2'd0:    ey -= 4;
            2'd1:    ey += 4;
            2'd2:    ex -= 4;
            default: ex += 4;
        endcase
        emoves++;
        if (emoves == 12) begin
            ebusy = 1'b0;
            if (edir == 2'd0 && ehops < 255) ehops++;
        end
        add(NONE, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic void hop_full(input int d, input logic [3:0] b);
        hop_start(d, b);
        for (int i = 0; i < 12; i++) hop_move(1'b0);
    endfunction

    function automatic void dead_tick(input logic [3:0] b);
        ex = 320; ey = 469; ehops = 0; edan = 1'b1; ebusy = 1'b0; efr = 30;
        add(b, 1'b1, 1'b1, 1'b1);
    endfunction

    function automatic void dead_step(input logic [3:0] b);
        efr--;
        if (efr == 0) edan = 1'b0;
        add(b, 1'b1, 1'b1, 1'b0);
    endfunction

    task automatic cmp(input string nm, input logic [59:0] exp);
        logic [59:0] act;
        act = {o_x1, o_x2, o_y1, o_y2, o_busy, o_dir, o_dead_anim, o_hops};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got x1=%0d x2=%0d y1=%0d y2=%0d busy=%0d dir=%0d dead=%0d hops=%0d, expected x1=%0d x2=%0d y1=%0d y2=%0d busy=%0d dir=%0d dead=%0d hops=%0d",
                     nm, act[59:48], act[47:36], act[35:24], act[23:12], act[11], act[10:9], act[8], act[7:0],
                     exp[59:48], exp[47:36], exp[35:24], exp[23:12], exp[11], exp[10:9], exp[8], exp[7:0]);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        {up_n, down_n, left_n, right_n} = v.btn_n;
        stb = v.stb; anim = v.anim; dead = v.dead;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp($sformatf("%s[%0d]", e.name, idx),
            {12'(e.ex - 11), 12'(e.ex + 11), 12'(e.ey - 11), 12'(e.ey + 11),
             e.busy, e.dir, e.dan, 8'(e.hops)});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- build the vector table ----
        phase = "reset";
        add(NONE, 1'b0, 1'b1, 1'b0);
        add(NONE, 1'b1, 1'b0, 1'b0);

        phase = "down_oob";
        add(DOWN, 1'b1, 1'b1, 1'b0);
        add(DOWN, 1'b0, 1'b1, 1'b0);
        add(NONE, 1'b1, 1'b1, 1'b0);

        phase = "multi_btn";
        add(4'b0110, 1'b1, 1'b0, 1'b0);
        hop_start(0, 4'b0110);
        for (int i = 0; i < 12; i++) hop_move(1'b1);

        phase = "pend_left";
        hop_start(0, UP);
        for (int i = 0; i < 5; i++) hop_move(1'b0);
        add(LEFT, 1'b0, 1'b1, 1'b0);
        add(NONE, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) hop_move(1'b0);
        hop_start(2, DOWN);
        for (int i = 0; i < 12; i++) hop_move(1'b0);
        phase = "pend_cleared";
        add(NONE, 1'b1, 1'b1, 1'b0);

        phase = "dead_idle";
        dead_tick(NONE);
        for (int i = 0; i < 10; i++) dead_step(UP);
        add(LEFT, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 19; i++) dead_step(UP);
        phase = "dead_exit";
        dead_step(UP);
        add(NONE, 1'b1, 1'b1, 1'b0);

        phase = "dead_midhop";
        hop_start(0, UP);
        for (int i = 0; i < 6; i++) hop_move(1'b0);
        dead_tick(RIGHT);
        for (int i = 0; i < 10; i++) dead_step(RIGHT);
        phase = "dead_reload";
        dead_tick(RIGHT);
        for (int i = 0; i < 30; i++) dead_step(RIGHT);
        add(NONE, 1'b1, 1'b1, 1'b0);

        phase = "up_bound";
        while (legal_hop(0)) hop_full(0, UP);
        add(UP, 1'b1, 1'b1, 1'b0);
        add(NONE, 1'b1, 1'b1, 1'b0);

        phase = "down_bound";
        while (legal_hop(1)) hop_full(1, DOWN);
        add(DOWN, 1'b1, 1'b1, 1'b0);
        add(NONE, 1'b1, 1'b1, 1'b0);

        phase = "right_bound";
        while (legal_hop(3)) hop_full(3, RIGHT);
        add(RIGHT, 1'b1, 1'b1, 1'b0);
        add(NONE, 1'b1, 1'b1, 1'b0);

        // ---- reset and apply ----
        rst_n = 1'b0;
        {up_n, down_n, left_n, right_n} = NONE;
        stb = 1'b0; anim = 1'b0; dead = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // ---- asynchronous reset mid-hop (from x=608, y=421, hops=9) ----
        @(negedge clk);
        up_n = 1'b0; stb = 1'b1; anim = 1'b1;
        @(negedge clk);
        up_n = 1'b1;
        repeat (3) @(negedge clk);
        cmp("pre_rst_hop", {12'd597, 12'd619, 12'd398, 12'd420, 1'b1, 2'd0, 1'b0, 8'd9});
        #2;
        rst_n = 1'b0; stb = 1'b0;
        #1;
        cmp("async_rst_hop", RST_OBS);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- asynchronous reset mid-DEAD ----
        @(negedge clk);
        dead = 1'b1; stb = 1'b1; anim = 1'b1;
        @(negedge clk);
        dead = 1'b0;
        cmp("pre_rst_dead", {12'd309, 12'd331, 12'd458, 12'd480, 1'b0, 2'd0, 1'b1, 8'd0});
        #2;
        rst_n = 1'b0; stb = 1'b0;
        #1;
        cmp("async_rst_dead", RST_OBS);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp("post_rst_idle", RST_OBS);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
